// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage of the 32-bit MIPS pipeline.
// Owns the PC and keeps at most one instruction-memory request in flight
// (req/gnt/rvalid). It feeds the IF/ID register with fetched words or NOP
// bubbles. Stalled words are parked in hold_buf. After a redirect, a fetch
// that is still in flight is drained in DROP and its word is thrown away.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        reset_n_in,
   input  logic        stall_in,
   input  logic        redirect_in,
   input  logic [31:0] redirect_pc_in,
   output logic        imem_req_out,
   output logic [31:0] imem_addr_out,
   input  logic        imem_gnt_in,
   input  logic        imem_rvalid_in,
   input  logic [31:0] imem_rdata_in,
   output logic [31:0] ifid_ins_out,
   output logic [31:0] ifid_pc_out,
   output logic        ifid_write_out,
   output logic        ifid_flush_out
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      HOLD = 3'd3,
      DROP = 3'd4
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc;
   logic [31:0] hold_buf;
   logic [31:0] pc_plus4;
   logic        deliver;   // a word enters IF/ID this cycle, so the PC advances
   logic        capture;   // the returning word arrives during a stall and is parked

   // Wraps modulo 2^32, so 32'hFFFF_FFFC + 4 gives 0.
   assign pc_plus4      = pc + 32'd4;
   assign imem_addr_out = {pc[31:2], 2'b00};

   // State register.
   always_ff @(posedge clk or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. A redirect takes priority over everything else. It
   // drains a fetch that is still in flight before a new request goes out.
   always_comb begin
      state_next = state;
      if (redirect_in) begin
         if ((state == WAIT || state == DROP) && !imem_rvalid_in) begin
            state_next = DROP;
         end else begin
            state_next = REQ;
         end
      end else begin
         case (state)
            IDLE: state_next = REQ;
            REQ:  if (imem_gnt_in) state_next = WAIT;
            WAIT: if (imem_rvalid_in) state_next = stall_in ? HOLD : REQ;
            HOLD: if (!stall_in) state_next = REQ;
            DROP: if (imem_rvalid_in) state_next = REQ;
            default: state_next = IDLE;
         endcase
      end
   end

   // Output logic. Bubbles write a NOP unless the hazard unit is stalling.
   // While reset is held, all outputs are forced to their quiet values.
   always_comb begin
      imem_req_out   = 1'b0;
      ifid_write_out = 1'b0;
      ifid_flush_out = 1'b0;
      ifid_ins_out   = 32'h0;
      ifid_pc_out    = pc_plus4;
      deliver        = 1'b0;
      capture        = 1'b0;
      if (reset_n_in) begin
         ifid_flush_out = redirect_in;
         imem_req_out   = (state == REQ) && !redirect_in;
         if (!redirect_in) begin
            case (state)
               IDLE: ifid_write_out = 1'b0;
               REQ, DROP: ifid_write_out = !stall_in;
               WAIT: begin
                  if (imem_rvalid_in) begin
                     if (!stall_in) begin
                        ifid_write_out = 1'b1;
                        ifid_ins_out   = imem_rdata_in;
                        deliver        = 1'b1;
                     end else begin
                        capture = 1'b1;
                     end
                  end else begin
                     ifid_write_out = !stall_in;
                  end
               end
               HOLD: begin
                  ifid_ins_out = hold_buf;
                  if (!stall_in) begin
                     ifid_write_out = 1'b1;
                     deliver        = 1'b1;
                  end
               end
               default: ifid_write_out = 1'b0;
            endcase
         end
      end
   end

   // PC and hold buffer. A redirect loads the word-aligned target and drops
   // any parked word.
   always_ff @(posedge clk or negedge reset_n_in) begin
      if (!reset_n_in) begin
         pc       <= RESET_PC;
         hold_buf <= 32'h0;
      end else if (redirect_in) begin
         pc       <= redirect_pc_in & ~32'd3;
         hold_buf <= 32'h0;
      end else begin
         if (deliver) pc <= pc_plus4;
         if (capture) hold_buf <= imem_rdata_in;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized scoreboard bench for if_fetch_unit.
// The reference model is the architectural instruction stream. Every granted
// fetch at the model PC pushes its (PC+4, word) into the queue. A redirect
// empties the queue and moves the model PC. The monitor pops one entry for
// every delivery it sees.
module tb_if_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0040_0000;
   localparam int NCYC = 3000;

   logic        clk = 1'b0;
   logic        reset_n_in;
   logic        stall_in;
   logic        redirect_in;
   logic [31:0] redirect_pc_in;
   logic        imem_req_out;
   logic [31:0] imem_addr_out;
   logic        imem_gnt_in;
   logic        imem_rvalid_in;
   logic [31:0] imem_rdata_in;
   logic [31:0] ifid_ins_out;
   logic [31:0] ifid_pc_out;
   logic        ifid_write_out;
   logic        ifid_flush_out;

   if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset_n_in(reset_n_in), .stall_in(stall_in),
      .redirect_in(redirect_in), .redirect_pc_in(redirect_pc_in),
      .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
      .imem_gnt_in(imem_gnt_in), .imem_rvalid_in(imem_rvalid_in),
      .imem_rdata_in(imem_rdata_in), .ifid_ins_out(ifid_ins_out),
      .ifid_pc_out(ifid_pc_out), .ifid_write_out(ifid_write_out),
      .ifid_flush_out(ifid_flush_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc4;
      logic [31:0] ins;
   } item_t;

   item_t       exp_q[$];
   logic [31:0] model_pc;
   int          checks = 0;
   int          errors = 0;
   int          deliv_cnt = 0;
   bit          in_reset = 1'b1;
   bit          idle_cycle = 1'b0;
   bit          done = 1'b0;

   // Memory model: at most one request in flight, returned after a latency
   bit          mem_busy = 1'b0;
   int          mem_cnt = 0;
   logic [31:0] mem_word;
   int          stray = 0;

   // Memory contents: never zero, so a delivery cannot be mistaken for a bubble
   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[31:2] ^ 30'h2A5A_5A5A, 2'b11};
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      model_pc = RESET_PC;
      mem_busy = 1'b0;
      mem_cnt  = 0;
   endtask

   // Monitor: compares DUT outputs against the model on every falling edge
   initial begin
      item_t       it;
      logic [31:0] exp_pc;
      forever begin
         @(negedge clk);
         if (!done) begin
            if (in_reset) begin
               check1("rst_req", imem_req_out, 1'b0);
               check1("rst_write", ifid_write_out, 1'b0);
               check1("rst_flush", ifid_flush_out, 1'b0);
               check32("rst_ins", ifid_ins_out, 32'h0);
               check32("rst_pc", ifid_pc_out, RESET_PC + 32'd4);
            end else begin
               check1("flush", ifid_flush_out, redirect_in);
               check1("write", ifid_write_out, !redirect_in && !stall_in && !idle_cycle);
               if (!redirect_in && ifid_write_out) begin
                  if (ifid_ins_out != 32'h0) begin
                     if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_delivery: got ins %h pc %h expected none",
                                 ifid_ins_out, ifid_pc_out);
                     end else begin
                        it = exp_q.pop_front();
                        check32("deliver_pc", ifid_pc_out, it.pc4);
                        check32("deliver_ins", ifid_ins_out, it.ins);
                        deliv_cnt++;
                        $display("deliver pc4=%h ins=%h", ifid_pc_out, ifid_ins_out);
                     end
                  end else begin
                     exp_pc = (exp_q.size() != 0) ? exp_q[0].pc4 : model_pc + 32'd4;
                     check32("bubble_pc", ifid_pc_out, exp_pc);
                  end
               end
            end
         end
      end
   end

   // Driver: drives the stimulus and the memory responses, and advances the model
   initial begin
      int reset_hold;
      int lat;
      bit pending_reset;
      bit phase_a;
      reset_n_in     = 1'b0;
      stall_in       = 1'b0;
      redirect_in    = 1'b0;
      redirect_pc_in = 32'h0;
      imem_gnt_in    = 1'b0;
      imem_rvalid_in = 1'b0;
      imem_rdata_in  = 32'h0;
      model_reset();
      reset_hold    = 1;
      pending_reset = 1'b0;
      lat           = 1;
      repeat (3) @(posedge clk);
      for (int c = 0; c < NCYC; c++) begin
         @(posedge clk);
         #1;
         idle_cycle = 1'b0;
         if (reset_hold > 0) begin
            reset_hold--;
            if (reset_hold == 0) begin
               reset_n_in = 1'b1;
               in_reset   = 1'b0;
               idle_cycle = 1'b1;
               stray      = 2;
               $display("reset released, cycle %0d", c);
            end
         end
         // Cycles 0-19: zero-wait memory with no stall and no redirect
         phase_a = (c < 20);
         if (phase_a) begin
            stall_in    = 1'b0;
            redirect_in = 1'b0;
            imem_gnt_in = 1'b1;
            lat         = 1;
         end else begin
            stall_in    = ($urandom_range(0, 3) == 0);
            redirect_in = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
               0:       redirect_pc_in = 32'hFFFF_FFFC;
               1:       redirect_pc_in = 32'h0040_0103;
               default: redirect_pc_in = $urandom;
            endcase
            imem_gnt_in = ($urandom_range(0, 1) == 1);
            lat         = $urandom_range(1, 4);
         end
         // Memory response; rvalid without a request in flight must be ignored
         if (mem_busy) begin
            if (mem_cnt == 1) begin
               imem_rvalid_in = 1'b1;
               imem_rdata_in  = mem_word;
               mem_busy       = 1'b0;
            end else begin
               mem_cnt--;
               imem_rvalid_in = 1'b0;
               imem_rdata_in  = $urandom;
            end
         end else if (stray > 0) begin
            stray--;
            imem_rvalid_in = 1'b1;
            imem_rdata_in  = $urandom;
         end else begin
            imem_rvalid_in = !phase_a && ($urandom_range(0, 9) == 0);
            imem_rdata_in  = $urandom;
         end
         #1;
         if (!in_reset) begin
            if (imem_req_out) begin
               check1("req_while_outstanding", mem_busy, 1'b0);
               if (imem_gnt_in) begin
                  item_t it;
                  check32("fetch_addr", imem_addr_out, model_pc);
                  $display("fetch addr=%h lat=%0d", imem_addr_out, lat);
                  mem_busy = 1'b1;
                  mem_cnt  = lat;
                  mem_word = word_of(imem_addr_out);
                  it.pc4   = model_pc + 32'd4;
                  it.ins   = word_of(model_pc);
                  exp_q.push_back(it);
                  model_pc = model_pc + 32'd4;
               end
            end
            if (redirect_in) begin
               exp_q.delete();
               model_pc = redirect_pc_in & ~32'd3;
               $display("redirect to %h", redirect_pc_in);
            end
         end
         if (c == 20) check32("zero_wait_deliveries", deliv_cnt, 32'd9);
         if (c == 1000 || c == 2200) pending_reset = 1'b1;
         // Assert reset in the middle of the cycle while a fetch is in flight
         if (pending_reset && mem_busy && !in_reset) begin
            #1;
            reset_n_in    = 1'b0;
            in_reset      = 1'b1;
            pending_reset = 1'b0;
            reset_hold    = 2;
            model_reset();
            #1;
            check1("async_rst_req", imem_req_out, 1'b0);
            $display("reset asserted mid-fetch, cycle %0d", c);
         end
      end
      @(negedge clk);
      done = 1'b1;
      checks++;
      if (deliv_cnt < 200) begin
         errors++;
         $display("FAIL delivery_count: got %0d expected at least 200", deliv_cnt);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
